// File: rtl/apb_spi_completer.sv
// apb_spi_completer
//   APB completer for the SPI bridge plus the SPI master behind it.
//   Register file (PADDR word index): 0 CTRL, 1 STATUS, 2 TXDATA, 3 RXDATA,
//   4 CLKDIV, 5-7 reserved. Mode-0, MSB-first, one byte per TXDATA write,
//   automatic chip select, SCLK half-period of CLKDIV+1 clk cycles.
//
// Ports
//   clk, rst        system clock (= PCLK), async active-low reset
//   PSEL..PWDATA    APB request (PADDR is the word index)
//   PRDATA, PREADY, PSLVERR  APB response, zero wait states
//   sclk, mosi, miso, cs_n   SPI pins (sclk idles low, cs_n active-low)
//
// Engine states
//   state    | meaning
//   ---------+------------------------------------------------------
//   ST_IDLE  | cs_n high, sclk low, waiting for a TXDATA write
//   ST_SHIFT | cs_n low, 16 sclk half-periods of CLKDIV+1 cycles each
//   ST_DONE  | one cycle: publish RXDATA, set RX_VALID / OVR
module apb_spi_completer #(
  parameter logic [7:0] DEFAULT_DIV = 8'd3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [2:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  output logic       PSLVERR,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       cs_n
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0] state;
  logic       en;
  logic [7:0] clkdiv;
  logic [7:0] rxdata;
  logic       rx_valid;
  logic       ovr;
  logic [7:0] div_lat;
  logic [7:0] div_cnt;
  logic [3:0] half_cnt;
  logic [7:0] tx_sh;
  logic [7:0] rx_sh;

  logic       access;
  logic       busy;
  logic       err;
  logic       wr_ok;
  logic       rd_ok;
  logic       en_nxt;

  assign access  = PSEL & PENABLE;
  assign PREADY  = access;
  assign busy    = (state != ST_IDLE);
  assign cs_n    = (state != ST_SHIFT);

  always_comb begin
    err = 1'b0;
    if (access) begin
      case (PADDR)
        3'd2:                err = PWRITE & (busy | ~en);
        3'd3:                err = PWRITE;
        3'd5, 3'd6, 3'd7:    err = 1'b1;
        default:             err = 1'b0;
      endcase
    end
  end

  assign PSLVERR = err;
  assign wr_ok   = access &  PWRITE & ~err;
  assign rd_ok   = access & ~PWRITE & ~err;

  // Abort must take effect on the same edge that clears EN so the bus
  // sees cs_n high in the very next cycle.
  assign en_nxt  = (wr_ok && PADDR == 3'd0) ? PWDATA[0] : en;

  always_comb begin
    PRDATA = 8'h00;
    if (access && !PWRITE) begin
      case (PADDR)
        3'd0:    PRDATA = {7'b0, en};
        3'd1:    PRDATA = {5'b0, ovr, rx_valid, busy};
        3'd3:    PRDATA = rxdata;
        3'd4:    PRDATA = clkdiv;
        default: PRDATA = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      en       <= 1'b0;
      clkdiv   <= DEFAULT_DIV;
      rxdata   <= 8'h00;
      rx_valid <= 1'b0;
      ovr      <= 1'b0;
      div_lat  <= 8'h00;
      div_cnt  <= 8'h00;
      half_cnt <= 4'd0;
      tx_sh    <= 8'h00;
      rx_sh    <= 8'h00;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
    end else begin
      if (wr_ok && PADDR == 3'd0) en     <= PWDATA[0];
      if (wr_ok && PADDR == 3'd4) clkdiv <= PWDATA;

      // Clears first; the DONE updates below override them (set wins).
      if (rd_ok && PADDR == 3'd3)                rx_valid <= 1'b0;
      if (wr_ok && PADDR == 3'd1 && PWDATA[2])   ovr      <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (wr_ok && PADDR == 3'd2) begin
            state    <= ST_SHIFT;
            tx_sh    <= PWDATA;
            mosi     <= PWDATA[7];
            div_lat  <= clkdiv;
            div_cnt  <= 8'h00;
            half_cnt <= 4'd0;
            sclk     <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (!en_nxt) begin
            state <= ST_IDLE;
            sclk  <= 1'b0;
          end else if (div_cnt == div_lat) begin
            div_cnt  <= 8'h00;
            sclk     <= ~sclk;
            half_cnt <= half_cnt + 4'd1;
            if (!sclk) begin
              rx_sh <= {rx_sh[6:0], miso};
            end else if (half_cnt != 4'd15) begin
              tx_sh <= {tx_sh[6:0], 1'b0};
              mosi  <= tx_sh[6];
            end
            if (half_cnt == 4'd15) state <= ST_DONE;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        ST_DONE: begin
          rxdata   <= rx_sh;
          rx_valid <= 1'b1;
          if (rx_valid) ovr <= 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_spi_completer.sv
module tb_apb_spi_completer;

  logic       clk = 1'b0;
  logic       rst;
  logic       PSEL, PENABLE, PWRITE;
  logic [2:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY, PSLVERR;
  logic       sclk, mosi, miso, cs_n;

  int n_checks = 0;
  int n_fail   = 0;

  // SPI target model: loopback or a fixed byte shifted out MSB first,
  // updated after each falling sclk edge.
  logic       lb = 1'b1;
  logic [7:0] slv_pat = 8'h00;
  logic [2:0] bidx = 3'd0;
  logic       miso_drv;

  always @(negedge sclk or posedge cs_n)
    if (cs_n) bidx <= 3'd0;
    else      bidx <= bidx + 3'd1;

  assign miso_drv = slv_pat[3'd7 - bidx];
  assign miso     = lb ? mosi : miso_drv;

  always #5 clk = ~clk;

  apb_spi_completer #(.DEFAULT_DIV(8'd3)) dut (
    .clk(clk), .rst(rst),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  task automatic apb_write(input logic [2:0] a, input logic [7:0] d, output logic e);
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(negedge clk);
    e = PSLVERR;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [2:0] a, output logic [7:0] d, output logic e);
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(negedge clk);
    d = PRDATA; e = PSLVERR;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic chk_reg(input string name, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] d; logic e;
    apb_read(a, d, e);
    n_checks++;
    if (d !== exp || e !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got %02h err=%b, expected %02h err=0", name, d, e, exp);
    end
  endtask

  task automatic wait_idle(input string name);
    logic [7:0] d; logic e; logic idle;
    idle = 1'b0;
    for (int i = 0; i < 200; i++) begin
      apb_read(3'd1, d, e);
      if (d[0] === 1'b0) begin idle = 1'b1; break; end
    end
    n_checks++;
    if (!idle) begin
      n_fail++;
      $display("FAIL %s: BUSY still %b after 200 polls, expected 0", name, d[0]);
    end
  endtask

  task automatic test_reset;
    logic [7:0] d; logic e;
    rst = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 3'd0; PWDATA = 8'h00;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cs_n, sclk, mosi, PREADY, PSLVERR, PRDATA} !== {5'b10000, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_outputs: cs_n=%b sclk=%b mosi=%b pready=%b pslverr=%b prdata=%02h, expected 1 0 0 0 0 00",
               cs_n, sclk, mosi, PREADY, PSLVERR, PRDATA);
    end
    rst = 1'b1;
    chk_reg("reset_ctrl",   3'd0, 8'h00);
    chk_reg("reset_status", 3'd1, 8'h00);
    chk_reg("reset_clkdiv", 3'd4, 8'h03);
    chk_reg("reset_rxdata", 3'd3, 8'h00);
    apb_read(3'd6, d, e);
    n_checks++;
    if (d !== 8'h00 || e !== 1'b1) begin
      n_fail++;
      $display("FAIL reserved_read: got %02h err=%b, expected 00 err=1", d, e);
    end
  endtask

  // Full cycle-by-cycle timeline of one transfer, with a STATUS read parked
  // on the bus so BUSY is visible every cycle.
  task automatic test_xfer(input string name, input logic [7:0] tx, input int dv,
                           input logic [7:0] exp_rx);
    logic e; int hp, last; logic exp_sclk, exp_mosi, exp_cs, exp_busy; int bad;
    apb_write(3'd4, dv[7:0], e);
    apb_write(3'd2, tx, e);
    n_checks++;
    if (e !== 1'b0) begin
      n_fail++; $display("FAIL %s_start: pslverr=%b, expected 0", name, e);
    end
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 3'd1;
    hp = dv + 1; last = 16 * hp; bad = 0;
    for (int j = 0; j <= last + 1; j++) begin
      @(negedge clk);
      exp_cs   = (j >= last);
      exp_sclk = (j < last) ? ((j / hp) % 2 == 1) : 1'b0;
      exp_mosi = (j < last) ? tx[7 - j / (2 * hp)] : tx[0];
      exp_busy = (j <= last);
      n_checks++;
      if ({cs_n, sclk, mosi, PRDATA[0]} !== {exp_cs, exp_sclk, exp_mosi, exp_busy}) begin
        n_fail++;
        if (bad < 8)
          $display("FAIL %s_timeline j=%0d: cs_n/sclk/mosi/busy=%b%b%b%b, expected %b%b%b%b",
                   name, j, cs_n, sclk, mosi, PRDATA[0], exp_cs, exp_sclk, exp_mosi, exp_busy);
        bad++;
      end
    end
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    chk_reg({name, "_status"},  3'd1, 8'h02);
    chk_reg({name, "_rxdata"},  3'd3, exp_rx);
    chk_reg({name, "_status2"}, 3'd1, 8'h00);
  endtask

  task automatic count_low(output int low);
    low = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cs_n) break;
      low++;
    end
  endtask

  task automatic test_overrun;
    logic e; int low;
    lb = 1'b1;
    apb_write(3'd4, 8'd3, e);
    apb_write(3'd2, 8'h11, e);
    fork
      count_low(low);
      apb_write(3'd4, 8'd0, e);
    join
    n_checks++;
    if (low !== 64) begin
      n_fail++; $display("FAIL clkdiv_latched: cs_n low %0d cycles, expected 64", low);
    end
    wait_idle("ovr_idle1");
    apb_write(3'd2, 8'h22, e);
    count_low(low);
    n_checks++;
    if (low !== 16) begin
      n_fail++; $display("FAIL clkdiv_new: cs_n low %0d cycles, expected 16", low);
    end
    wait_idle("ovr_idle2");
    chk_reg("ovr_status",    3'd1, 8'h06);
    apb_write(3'd1, 8'h04, e);
    chk_reg("ovr_cleared",   3'd1, 8'h02);
    chk_reg("ovr_rxdata",    3'd3, 8'h22);
    chk_reg("ovr_status_rd", 3'd1, 8'h00);
  endtask

  task automatic test_errors;
    logic e; logic stayed;
    lb = 1'b1;
    apb_write(3'd2, 8'h5A, e);
    apb_write(3'd2, 8'hFF, e);
    n_checks++;
    if (e !== 1'b1) begin
      n_fail++; $display("FAIL tx_while_busy: pslverr=%b, expected 1", e);
    end
    wait_idle("err_idle");
    chk_reg("busy_uncorrupted", 3'd3, 8'h5A);
    apb_write(3'd3, 8'h12, e);
    n_checks++;
    if (e !== 1'b1) begin
      n_fail++; $display("FAIL rxdata_write: pslverr=%b, expected 1", e);
    end
    apb_write(3'd0, 8'h00, e);
    apb_write(3'd2, 8'h77, e);
    stayed = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cs_n !== 1'b1) stayed = 1'b0;
    end
    n_checks++;
    if (e !== 1'b1 || stayed !== 1'b1) begin
      n_fail++; $display("FAIL tx_disabled: pslverr=%b cs_n_stayed_high=%b, expected 1 1", e, stayed);
    end
    chk_reg("disabled_status", 3'd1, 8'h00);
  endtask

  task automatic test_abort;
    logic e; logic prev; int rises;
    lb = 1'b0; slv_pat = 8'hF0;
    apb_write(3'd0, 8'h01, e);
    apb_write(3'd4, 8'd1, e);
    apb_write(3'd2, 8'h96, e);
    rises = 0; prev = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sclk && !prev) rises++;
      prev = sclk;
      if (rises == 3) break;
    end
    n_checks++;
    if (rises !== 3) begin
      n_fail++; $display("FAIL abort_rises: saw %0d rising sclk edges, expected 3", rises);
    end
    apb_write(3'd0, 8'h00, e);
    @(negedge clk);
    n_checks++;
    if (cs_n !== 1'b1 || sclk !== 1'b0) begin
      n_fail++; $display("FAIL abort_pins: cs_n=%b sclk=%b, expected 1 0", cs_n, sclk);
    end
    chk_reg("abort_status", 3'd1, 8'h00);
    chk_reg("abort_rxdata", 3'd3, 8'h5A);
  endtask

  task automatic test_reset_mid;
    logic e;
    lb = 1'b1;
    apb_write(3'd0, 8'h01, e);
    apb_write(3'd4, 8'd1, e);
    apb_write(3'd2, 8'h81, e);
    repeat (4) @(negedge clk);
    n_checks++;
    if ({cs_n, sclk, mosi} !== 3'b011) begin
      n_fail++; $display("FAIL pre_reset: cs_n/sclk/mosi=%b%b%b, expected 011", cs_n, sclk, mosi);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({cs_n, sclk, mosi, PREADY, PSLVERR, PRDATA} !== {5'b10000, 8'h00}) begin
      n_fail++;
      $display("FAIL async_reset: cs_n=%b sclk=%b mosi=%b pready=%b pslverr=%b prdata=%02h, expected 1 0 0 0 0 00",
               cs_n, sclk, mosi, PREADY, PSLVERR, PRDATA);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk_reg("rst_ctrl",   3'd0, 8'h00);
    chk_reg("rst_clkdiv", 3'd4, 8'h03);
    chk_reg("rst_status", 3'd1, 8'h00);
    chk_reg("rst_rxdata", 3'd3, 8'h00);
  endtask

  initial begin
    logic e;
    test_reset;
    apb_write(3'd0, 8'h01, e);
    chk_reg("ctrl_en", 3'd0, 8'h01);
    lb = 1'b1;
    test_xfer("div0_a5", 8'hA5, 0, 8'hA5);
    lb = 1'b0; slv_pat = 8'hC3;
    test_xfer("div3_3c", 8'h3C, 3, 8'hC3);
    test_overrun;
    test_errors;
    test_abort;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_spi_completer.md
# apb_spi_completer

APB completer that terminates the SPI bridge's APB bus and implements the SPI controller behind it. It decodes PADDR word indices into an 8-bit register file and runs a mode-0, MSB-first SPI master shift engine. The engine moves one byte per TXDATA write, with automatic chip select and a programmable SCLK divider. It sits at SPI_BASE (0x1000_0000–0x1000_001F) on the RISC-V memory map.

## Interface
- DEFAULT_DIV, 8'd3, reset value of CLKDIV; SCLK half-period = CLKDIV+1 clk cycles
- clk  in  1  system clock (same as PCLK)
- rst  in  1  reset, asynchronous, active-low
- PSEL  in  1  APB select
- PENABLE  in  1  APB access phase
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  3  register word index (mem_addr[4:2])
- PWDATA  in  8  write data
- PRDATA  out  8  read data; valid in the access phase, 0 otherwise
- PREADY  out  1  transfer complete; equals PSEL&PENABLE (zero wait states)
- PSLVERR  out  1  error response; valid only while PREADY=1
- sclk  out  1  SPI clock, idle low
- mosi  out  1  SPI data out
- miso  in  1  SPI data in
- cs_n  out  1  SPI chip select, active-low

## Operation
- Register map, by PADDR:
  - 0 CTRL (RW): bit0 EN; other bits read 0.
  - 1 STATUS: bit0 BUSY (RO), bit1 RX_VALID (RO), bit2 OVR (sticky; write 1 to clear).
  - 2 TXDATA (WO, reads 0): starts a transfer.
  - 3 RXDATA (RO): a read clears RX_VALID.
  - 4 CLKDIV (RW).
  - 5–7 reserved.
- An access is accepted in a cycle with PSEL=1, PENABLE=1 and PREADY=1. Register writes take effect on that clock edge.
- PSLVERR=1 in the following cases; the access then has no side effects:
  - any access to 5–7;
  - a write to RXDATA;
  - a write to TXDATA while BUSY=1 or EN=0.
- Engine states:
  - IDLE: cs_n=1, sclk=0. An accepted TXDATA write loads the shift register and moves to SHIFT.
  - SHIFT: 16 half-periods, with a divider counter from 0 to CLKDIV.
    - Odd half-period ends (rising sclk): sample miso into the LSB of the rx shift register.
    - Even half-period ends (falling sclk): shift the next tx bit onto mosi.
    - After the 16th half-period end, move to DONE.
  - DONE (1 cycle):
    - RXDATA <= rx shift register; RX_VALID <= 1.
    - If RX_VALID was already 1, also set OVR <= 1.
    - cs_n=1, then return to IDLE.
- BUSY=1 in SHIFT and DONE.
- CLKDIV writes during SHIFT are accepted, but the engine uses the value latched at transfer start.
- EN cleared during SHIFT aborts the transfer:
  - next cycle: cs_n=1, sclk=0, BUSY=0, state IDLE;
  - RXDATA, RX_VALID and OVR are unchanged.
- Simultaneous events:
  - DONE in the same cycle as a RXDATA read: the read returns the old RXDATA. RX_VALID ends at 1 (set wins over clear). OVR is set only if RX_VALID was 1 before that cycle.
  - DONE in the same cycle as an OVR clear write: set wins.

## Timing
- Reset values:
  - PRDATA=0, PREADY=0, PSLVERR=0.
  - sclk=0, mosi=0, cs_n=1.
  - CTRL=0, CLKDIV=DEFAULT_DIV, RXDATA=0, RX_VALID=0, OVR=0.
  - State IDLE.
- Reset mid-transfer returns to these values immediately (asynchronously).
- APB reads and writes complete in 2 cycles (setup + access) with no wait states. PRDATA and PSLVERR are combinational from the registers during the access phase.
- Transfer timeline with D = latched CLKDIV and T0 = the cycle after the TXDATA write edge:
  - From T0: cs_n=0, mosi=bit7, sclk=0.
  - Rising sclk edges at T0+(2k+1)(D+1), k=0..7.
  - Falling sclk edges at T0+(2k+2)(D+1), k=0..6; mosi changes to the next bit on each.
  - Last rising edge at T0+15(D+1).
  - DONE at T0+16(D+1); cs_n=1 and BUSY=0 at T0+16(D+1)+1.
- Back-to-back transfers: a TXDATA write is accepted in the first cycle BUSY reads 0. cs_n is high for at least 1 cycle between bytes.

## Test plan
- Reset then read all registers: CTRL=0x00, STATUS=0x00, CLKDIV=0x03; read of PADDR=6 -> PRDATA=0, PSLVERR=1.
- EN=1, CLKDIV=0, TXDATA=0xA5 with miso looped to mosi:
  - sclk period 2 clk; mosi sequence 1,0,1,0,0,1,0,1;
  - BUSY falls 17 cycles after T0; RXDATA=0xA5, STATUS=0x02.
- CLKDIV=3, TXDATA=0x3C, miso driven with 0xC3:
  - sclk high for 4 and low for 4 clk per bit; cs_n low for 64 cycles;
  - RXDATA=0xC3.
- Two transfers without reading RXDATA: STATUS=0x06. Writing 0x04 to STATUS -> 0x02. A RXDATA read returns the second byte, then STATUS=0x00.
- TXDATA write while BUSY -> PSLVERR=1 and the current byte is uncorrupted. TXDATA write with EN=0 -> PSLVERR=1 and cs_n stays 1.
- Clear EN after 3 sclk rising edges: cs_n=1 and sclk=0 next cycle; RX_VALID stays 0 and RXDATA is unchanged. Assert rst mid-transfer: all outputs return to reset values.
